simmem_mem_responder: RTL and testbench

- Behavioural far-end memory responder for the simulated-memory path. It consumes the requester-side AXI traffic that the delay calculator snoops: write address, write data beats and read address.
- It produces the real write responses and read data bursts that feed the response banks.
- Write data beats may arrive before, with, or after their write address. Beats are bound to writes strictly in address order.

---
 rtl/simmem_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_simmem_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/simmem_mem_responder.sv
// Behavioural far-end memory for the simulated-memory path: binds write beats to
// write addresses in order to produce write responses, and plays out read bursts.
package simmem_pkg;

    localparam int IdWidth        = 4;
    localparam int BurstLenWidth  = 3;
    localparam int DataWidth      = 32;
    localparam int MaxBurstEffLen = 1 << BurstLenWidth;

    typedef struct packed {
        logic [IdWidth-1:0]       id;
        logic [BurstLenWidth-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [IdWidth-1:0]       id;
        logic [BurstLenWidth-1:0] burst_len;
    } raddr_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         rsp;
    } wrsp_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           rsp;
        logic                 last;
    } rdata_t;

    function automatic int unsigned get_effective_burst_len(logic [BurstLenWidth-1:0] burst_len);
        return int'(burst_len) + 1;
    endfunction

endpackage

module simmem_mem_responder
    import simmem_pkg::*;
#(
    parameter int WAddrDepth = 4,
    parameter int RAddrDepth = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  waddr_t waddr_i,
    input  logic   waddr_valid_i,
    output logic   waddr_ready_o,
    input  logic   wdata_valid_i,
    output logic   wdata_ready_o,
    input  raddr_t raddr_i,
    input  logic   raddr_valid_i,
    output logic   raddr_ready_o,
    output wrsp_t  wrsp_o,
    output logic   wrsp_valid_o,
    input  logic   wrsp_ready_i,
    output rdata_t rdata_o,
    output logic   rdata_valid_o,
    input  logic   rdata_ready_i
);

    localparam int LenW   = $clog2(MaxBurstEffLen + 1);
    localparam int WPtrW  = $clog2(WAddrDepth);
    localparam int WCntW  = $clog2(WAddrDepth + 1);
    localparam int RPtrW  = $clog2(RAddrDepth);
    localparam int RCntW  = $clog2(RAddrDepth + 1);

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;

    logic [IdWidth-1:0] wq_id  [WAddrDepth];
    logic [LenW-1:0]    wq_len [WAddrDepth];
    logic [WPtrW-1:0]   wq_wptr, wq_rptr;
    logic [WCntW-1:0]   wq_cnt;
    logic [LenW-1:0]    wcnt_q;
    logic [IdWidth-1:0] wrsp_id_q;
    logic               wrsp_valid_q;

    logic               w_push, w_pop, w_beat;
    logic [LenW-1:0]    w_sum, w_head_len;

    logic [IdWidth-1:0] rq_id  [RAddrDepth];
    logic [LenW-1:0]    rq_len [RAddrDepth];
    logic [RPtrW-1:0]   rq_wptr, rq_rptr;
    logic [RCntW-1:0]   rq_cnt;
    rd_state_e          rd_state_q;
    logic [IdWidth-1:0] r_id_q;
    logic [LenW-1:0]    r_len_q, r_beat_q;

    logic               r_push, r_pop, r_last, r_hs;

    assign waddr_ready_o = (wq_cnt != WCntW'(WAddrDepth));
    assign wdata_ready_o = (wcnt_q < LenW'(MaxBurstEffLen));
    assign raddr_ready_o = (rq_cnt != RCntW'(RAddrDepth));

    assign w_push     = waddr_valid_i && waddr_ready_o;
    assign w_beat     = wdata_valid_i && wdata_ready_o;
    assign w_sum      = wcnt_q + LenW'(w_beat);
    assign w_head_len = wq_len[wq_rptr];
    // A beat accepted this cycle counts towards completing the head write.
    assign w_pop      = (wq_cnt != '0) && (w_sum >= w_head_len)
                        && (!wrsp_valid_q || wrsp_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wq_wptr      <= '0;
            wq_rptr      <= '0;
            wq_cnt       <= '0;
            wcnt_q       <= '0;
            wrsp_valid_q <= 1'b0;
        end else begin
            if (w_push) wq_wptr <= wq_wptr + 1'b1;
            if (w_pop)  wq_rptr <= wq_rptr + 1'b1;
            wq_cnt <= wq_cnt + WCntW'(w_push) - WCntW'(w_pop);
            wcnt_q <= w_pop ? (w_sum - w_head_len) : w_sum;
            if (w_pop)             wrsp_valid_q <= 1'b1;
            else if (wrsp_ready_i) wrsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            wq_id[wq_wptr]  <= waddr_i.id;
            wq_len[wq_wptr] <= LenW'(get_effective_burst_len(waddr_i.burst_len));
        end
        if (w_pop) wrsp_id_q <= wq_id[wq_rptr];
    end

    always_comb begin
        wrsp_o    = '0;
        wrsp_o.id = wrsp_id_q;
    end
    assign wrsp_valid_o = wrsp_valid_q;

    assign r_push = raddr_valid_i && raddr_ready_o;
    assign r_last = (r_beat_q == r_len_q - LenW'(1));
    assign r_hs   = (rd_state_q == RD_BURST) && rdata_ready_i;
    // Reloading on the last handshake keeps consecutive bursts bubble-free.
    assign r_pop  = (rq_cnt != '0) && ((rd_state_q == RD_IDLE) || (r_hs && r_last));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rq_wptr    <= '0;
            rq_rptr    <= '0;
            rq_cnt     <= '0;
            rd_state_q <= RD_IDLE;
        end else begin
            if (r_push) rq_wptr <= rq_wptr + 1'b1;
            if (r_pop)  rq_rptr <= rq_rptr + 1'b1;
            rq_cnt <= rq_cnt + RCntW'(r_push) - RCntW'(r_pop);
            case (rd_state_q)
                RD_IDLE:  if (r_pop) rd_state_q <= RD_BURST;
                RD_BURST: if (r_hs && r_last && !r_pop) rd_state_q <= RD_IDLE;
                default:  rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_push) begin
            rq_id[rq_wptr]  <= raddr_i.id;
            rq_len[rq_wptr] <= LenW'(get_effective_burst_len(raddr_i.burst_len));
        end
        if (r_pop) begin
            r_id_q   <= rq_id[rq_rptr];
            r_len_q  <= rq_len[rq_rptr];
            r_beat_q <= '0;
        end else if (r_hs && !r_last) begin
            r_beat_q <= r_beat_q + 1'b1;
        end
    end

    always_comb begin
        rdata_o      = '0;
        rdata_o.id   = r_id_q;
        rdata_o.data = DataWidth'(r_beat_q);
        rdata_o.last = r_last;
    end
    assign rdata_valid_o = (rd_state_q == RD_BURST);

    a_wcnt_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wcnt_q <= LenW'(MaxBurstEffLen));
    a_no_valid_in_reset: assert property (@(posedge clk_i)
        !rst_ni |-> (!wrsp_valid_o && !rdata_valid_o));
    a_wrsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wrsp_valid_o && !wrsp_ready_i) |=> (wrsp_valid_o && $stable(wrsp_o)));
    a_rdata_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rdata_valid_o && !rdata_ready_i) |=> (rdata_valid_o && $stable(rdata_o)));

endmodule

// File: tb/tb_simmem_mem_responder.sv
// Directed bench for simmem_mem_responder: write binding, back-pressure, reads, reset.
module tb_simmem_mem_responder;
    import simmem_pkg::*;

    logic   clk_i = 1'b0;
    logic   rst_ni;
    waddr_t waddr_i;
    logic   waddr_valid_i, waddr_ready_o;
    logic   wdata_valid_i, wdata_ready_o;
    raddr_t raddr_i;
    logic   raddr_valid_i, raddr_ready_o;
    wrsp_t  wrsp_o;
    logic   wrsp_valid_o, wrsp_ready_i;
    rdata_t rdata_o;
    logic   rdata_valid_o, rdata_ready_i;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_beat;

    simmem_mem_responder #(.WAddrDepth(4), .RAddrDepth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .waddr_i(waddr_i), .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
        .wrsp_o(wrsp_o), .wrsp_valid_o(wrsp_valid_o), .wrsp_ready_i(wrsp_ready_i),
        .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input int id, input int beat, input int last);
        check({tag, "_v"},  32'(rdata_valid_o), 32'd1);
        check({tag, "_id"}, 32'(rdata_o.id), 32'(id));
        check({tag, "_d"},  rdata_o.data, 32'(beat));
        check({tag, "_l"},  32'(rdata_o.last), 32'(last));
    endtask

    initial begin
        rst_ni = 1'b0;
        waddr_i = '0; waddr_valid_i = 1'b0; wdata_valid_i = 1'b0;
        raddr_i = '0; raddr_valid_i = 1'b0;
        wrsp_ready_i = 1'b1; rdata_ready_i = 1'b1;
        #1;
        check("rst_wrsp_valid", 32'(wrsp_valid_o), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid_o), 32'd0);
        tick(); tick();
        rst_ni = 1'b1;
        check("rst_waddr_ready", 32'(waddr_ready_o), 32'd1);
        check("rst_raddr_ready", 32'(raddr_ready_o), 32'd1);
        check("rst_wdata_ready", 32'(wdata_ready_o), 32'd1);

        // Single write id=5 L=4: address then four beats.
        waddr_i.id = 4'd5; waddr_i.burst_len = 3'd3; waddr_valid_i = 1'b1; wdata_valid_i = 1'b1;
        tick(); waddr_valid_i = 1'b0;
        tick(); tick();
        check("w1_early", 32'(wrsp_valid_o), 32'd0);
        tick(); wdata_valid_i = 1'b0;
        check("w1_valid", 32'(wrsp_valid_o), 32'd1);
        check("w1_id", 32'(wrsp_o.id), 32'd5);
        tick();
        check("w1_clear", 32'(wrsp_valid_o), 32'd0);

        // Minimum latency: address with last beat -> response two cycles later.
        wdata_valid_i = 1'b1;
        repeat (3) tick();
        waddr_i.id = 4'd6; waddr_i.burst_len = 3'd3; waddr_valid_i = 1'b1;
        tick(); waddr_valid_i = 1'b0; wdata_valid_i = 1'b0;
        check("wmin_n1", 32'(wrsp_valid_o), 32'd0);
        tick();
        check("wmin_n2", 32'(wrsp_valid_o), 32'd1);
        check("wmin_id", 32'(wrsp_o.id), 32'd6);
        tick();
        check("wmin_clear", 32'(wrsp_valid_o), 32'd0);

        // Beats first: 8 beats fill the counter, then writes L=4, L=2, L=2.
        wdata_valid_i = 1'b1;
        repeat (8) tick();
        wdata_valid_i = 1'b0;
        check("bf_wdata_full", 32'(wdata_ready_o), 32'd0);
        waddr_i.id = 4'd1; waddr_i.burst_len = 3'd3; waddr_valid_i = 1'b1;
        tick();
        check("bf_still_full", 32'(wdata_ready_o), 32'd0);
        waddr_i.id = 4'd2; waddr_i.burst_len = 3'd1;
        tick(); waddr_valid_i = 1'b0;
        check("bf_id1_v", 32'(wrsp_valid_o), 32'd1);
        check("bf_id1", 32'(wrsp_o.id), 32'd1);
        check("bf_wdata_open", 32'(wdata_ready_o), 32'd1);
        tick();
        check("bf_id2_v", 32'(wrsp_valid_o), 32'd1);
        check("bf_id2", 32'(wrsp_o.id), 32'd2);
        waddr_i.id = 4'd3; waddr_i.burst_len = 3'd1; waddr_valid_i = 1'b1;
        tick(); waddr_valid_i = 1'b0;
        check("bf_gap", 32'(wrsp_valid_o), 32'd0);
        tick();
        check("bf_carry_v", 32'(wrsp_valid_o), 32'd1);
        check("bf_carry_id", 32'(wrsp_o.id), 32'd3);
        tick();
        check("bf_done", 32'(wrsp_valid_o), 32'd0);

        // Back-pressure with three completable writes plus a full address FIFO.
        wrsp_ready_i = 1'b0;
        waddr_i.burst_len = 3'd0; waddr_valid_i = 1'b1; wdata_valid_i = 1'b1;
        waddr_i.id = 4'd9;  tick();
        waddr_i.id = 4'd10; tick();
        waddr_i.id = 4'd11; tick();
        wdata_valid_i = 1'b0;
        waddr_i.id = 4'd12; tick();
        waddr_i.id = 4'd13; tick();
        waddr_valid_i = 1'b0;
        check("bp_waddr_full", 32'(waddr_ready_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_v", 32'(wrsp_valid_o), 32'd1);
            check("bp_hold_id", 32'(wrsp_o.id), 32'd9);
            tick();
        end
        wrsp_ready_i = 1'b1;
        tick();
        check("bp_id10", 32'(wrsp_o.id), 32'd10);
        check("bp_waddr_open", 32'(waddr_ready_o), 32'd1);
        tick();
        check("bp_id11_v", 32'(wrsp_valid_o), 32'd1);
        check("bp_id11", 32'(wrsp_o.id), 32'd11);
        tick();
        check("bp_starved", 32'(wrsp_valid_o), 32'd0);
        wdata_valid_i = 1'b1;
        tick();
        check("bp_id12_v", 32'(wrsp_valid_o), 32'd1);
        check("bp_id12", 32'(wrsp_o.id), 32'd12);
        tick(); wdata_valid_i = 1'b0;
        check("bp_id13", 32'(wrsp_o.id), 32'd13);
        tick();
        check("bp_done", 32'(wrsp_valid_o), 32'd0);

        // Reads: id=3 L=2 then id=7 L=1, back to back.
        raddr_i.id = 4'd3; raddr_i.burst_len = 3'd1; raddr_valid_i = 1'b1;
        tick();
        check("rd_lat1", 32'(rdata_valid_o), 32'd0);
        raddr_i.id = 4'd7; raddr_i.burst_len = 3'd0;
        tick(); raddr_valid_i = 1'b0;
        check_rd("rd_b0", 3, 0, 0);
        tick(); check_rd("rd_b1", 3, 1, 1);
        tick(); check_rd("rd_b2", 7, 0, 1);
        tick();
        check("rd_idle", 32'(rdata_valid_o), 32'd0);

        // Read stall: ready toggles, each beat held until consumed.
        rdata_ready_i = 1'b0;
        raddr_i.id = 4'd4; raddr_i.burst_len = 3'd2; raddr_valid_i = 1'b1;
        tick(); raddr_valid_i = 1'b0;
        tick();
        exp_beat = 0;
        for (int c = 0; c < 6; c++) begin
            rdata_ready_i = (c % 2 == 1);
            check_rd("rs_beat", 4, exp_beat, (exp_beat == 2) ? 1 : 0);
            tick();
            if (rdata_ready_i) exp_beat++;
        end
        check("rs_idle", 32'(rdata_valid_o), 32'd0);

        // Reset mid-burst with a pending write.
        rdata_ready_i = 1'b1;
        raddr_i.id = 4'd8; raddr_i.burst_len = 3'd3; raddr_valid_i = 1'b1;
        waddr_i.id = 4'd14; waddr_i.burst_len = 3'd1; waddr_valid_i = 1'b1; wdata_valid_i = 1'b1;
        tick();
        raddr_valid_i = 1'b0; waddr_valid_i = 1'b0; wdata_valid_i = 1'b0;
        tick(); check_rd("rr_b0", 8, 0, 0);
        tick(); check_rd("rr_b1", 8, 1, 0);
        #1 rst_ni = 1'b0;
        #1;
        check("rr_rdata_v", 32'(rdata_valid_o), 32'd0);
        check("rr_wrsp_v", 32'(wrsp_valid_o), 32'd0);
        check("rr_raddr_ready", 32'(raddr_ready_o), 32'd1);
        tick(); tick();
        rst_ni = 1'b1;
        wdata_valid_i = 1'b1;
        tick(); tick();
        wdata_valid_i = 1'b0;
        check("rr_no_stale_w", 32'(wrsp_valid_o), 32'd0);
        check("rr_no_stale_r", 32'(rdata_valid_o), 32'd0);
        tick();
        check("rr_no_stale_w2", 32'(wrsp_valid_o), 32'd0);
        check("rr_no_stale_r2", 32'(rdata_valid_o), 32'd0);
        waddr_i.id = 4'd15; waddr_i.burst_len = 3'd0; waddr_valid_i = 1'b1;
        tick(); waddr_valid_i = 1'b0;
        tick();
        check("rr_fresh_v", 32'(wrsp_valid_o), 32'd1);
        check("rr_fresh_id", 32'(wrsp_o.id), 32'd15);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
